branch_resolve_ctrl: RTL and testbench

// - Sequences early (ID-stage) branch resolution for the 5-stage MIPS pipeline.
// - Detects data hazards on branch operands Rs/Rt and inserts the stall cycles they need.
// - Drives the forwarding selects for the ID-stage compare unit.
// - On a taken branch, raises the redirect (BranchTaken) and the IF/ID squash (FlushIF).

---
 rtl/branch_resolve_ctrl.sv | 130 +++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolution controller: hazard stalls, compare-unit forwarding, redirect/squash.
// Optional statistics counters are enabled by defining BR_STAT_EN.
module branch_resolve_ctrl #(
  parameter int unsigned LOAD_STALL = 2,
  parameter int unsigned STAT_W     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ID_Branch,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       Branch,
  input  logic       EX_RegWrite,
  input  logic       EX_MemRead,
  input  logic [4:0] EX_Rd,
  input  logic       MEM_RegWrite,
  input  logic       MEM_MemRead,
  input  logic [4:0] MEM_Rd,
  input  logic       WB_RegWrite,
  input  logic [4:0] WB_Rd,
  input  logic       Freeze,
  input  logic       Flush,
  output logic       Stall,
  output logic       FlushIF,
  output logic       BranchTaken,
  output logic [1:0] FwdA,
  output logic [1:0] FwdB
`ifdef BR_STAT_EN
  ,
  output logic [STAT_W-1:0] StatTaken,
  output logic [STAT_W-1:0] StatStall
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, RESOLVE} state_t;

  state_t     state, state_next;
  logic [1:0] cnt, cnt_next;
  logic [1:0] need;
  logic       ex_hit, mem_hit;

  assign ex_hit  = (EX_Rd  != '0) && ((EX_Rd  == ID_Rs) || (EX_Rd  == ID_Rt));
  assign mem_hit = (MEM_Rd != '0) && ((MEM_Rd == ID_Rs) || (MEM_Rd == ID_Rt));

  always_comb begin
    need = 2'd0;
    if (EX_RegWrite && EX_MemRead && ex_hit)
      need = 2'(LOAD_STALL);
    else if (EX_RegWrite && ex_hit)
      need = 2'd1;
    else if (MEM_MemRead && MEM_RegWrite && mem_hit)
      need = 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    Stall       = 1'b0;
    FlushIF     = 1'b0;
    BranchTaken = 1'b0;
    FwdA        = 2'b00;
    FwdB        = 2'b00;
    if (!reset) begin
      if (MEM_RegWrite && !MEM_MemRead && (MEM_Rd == ID_Rs) && (ID_Rs != '0))
        FwdA = 2'b01;
      else if (WB_RegWrite && (WB_Rd == ID_Rs) && (ID_Rs != '0))
        FwdA = 2'b10;
      if (MEM_RegWrite && !MEM_MemRead && (MEM_Rd == ID_Rt) && (ID_Rt != '0))
        FwdB = 2'b01;
      else if (WB_RegWrite && (WB_Rd == ID_Rt) && (ID_Rt != '0))
        FwdB = 2'b10;

      if (Flush) begin
        state_next = IDLE;
        cnt_next   = '0;
      end else if (!Freeze) begin
        unique case (state)
          IDLE: begin
            if (ID_Branch) begin
              if (need == 2'd0) begin
                BranchTaken = Branch;
                FlushIF     = Branch;
              end else begin
                Stall      = 1'b1;
                cnt_next   = need - 2'd1;
                state_next = (need == 2'd1) ? RESOLVE : WAIT;
              end
            end
          end
          WAIT: begin
            Stall = 1'b1;
            if (cnt == 2'd1) state_next = RESOLVE;
            else             cnt_next   = cnt - 2'd1;
          end
          RESOLVE: begin
            // A dropped ID_Branch here is illegal; never redirect on it.
            BranchTaken = Branch & ID_Branch;
            FlushIF     = Branch & ID_Branch;
            state_next  = IDLE;
          end
          default: state_next = IDLE;
        endcase
      end
    end
  end

`ifdef BR_STAT_EN
  // Stall/BranchTaken are already forced low under Freeze, so the counters hold then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StatTaken <= '0;
      StatStall <= '0;
    end else begin
      if (BranchTaken && (StatTaken != '1)) StatTaken <= StatTaken + STAT_W'(1);
      if (Stall && (StatStall != '1))       StatStall <= StatStall + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: single-cycle vector table plus multi-cycle sequences.
module tb_branch_resolve_ctrl;

  typedef struct {
    logic       ib;
    logic [4:0] rs, rt;
    logic       br;
    logic       exw, exm;
    logic [4:0] exrd;
    logic       mw, mm;
    logic [4:0] mrd;
    logic       ww;
    logic [4:0] wrd;
    logic       frz, fl;
    logic [6:0] exp_out;  // {Stall, FlushIF, BranchTaken, FwdA, FwdB}
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       ID_Branch, Branch, EX_RegWrite, EX_MemRead, MEM_RegWrite, MEM_MemRead;
  logic       WB_RegWrite, Freeze, Flush;
  logic [4:0] ID_Rs, ID_Rt, EX_Rd, MEM_Rd, WB_Rd;
  logic       Stall, FlushIF, BranchTaken;
  logic [1:0] FwdA, FwdB;
`ifdef BR_STAT_EN
  logic [15:0] StatTaken, StatStall;
`endif

  int tests = 0;
  int fails = 0;

  branch_resolve_ctrl #(.LOAD_STALL(2), .STAT_W(16)) dut (
    .clk(clk), .reset(reset), .ID_Branch(ID_Branch), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .Branch(Branch), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead), .MEM_Rd(MEM_Rd),
    .WB_RegWrite(WB_RegWrite), .WB_Rd(WB_Rd), .Freeze(Freeze), .Flush(Flush),
    .Stall(Stall), .FlushIF(FlushIF), .BranchTaken(BranchTaken), .FwdA(FwdA), .FwdB(FwdB)
`ifdef BR_STAT_EN
    , .StatTaken(StatTaken), .StatStall(StatStall)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic ib, input logic [4:0] rs, input logic [4:0] rt,
                              input logic br, input logic exw, input logic exm,
                              input logic [4:0] exrd, input logic mw, input logic mm,
                              input logic [4:0] mrd, input logic ww, input logic [4:0] wrd,
                              input logic frz, input logic fl, input logic [6:0] e);
    vec_t v;
    v.ib = ib; v.rs = rs; v.rt = rt; v.br = br; v.exw = exw; v.exm = exm; v.exrd = exrd;
    v.mw = mw; v.mm = mm; v.mrd = mrd; v.ww = ww; v.wrd = wrd; v.frz = frz; v.fl = fl;
    v.exp_out = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [6:0] e);
    logic [6:0] act;
    act = {Stall, FlushIF, BranchTaken, FwdA, FwdB};
    tests++;
    if (act !== e) begin
      fails++;
      $display("FAIL %s: got {stall,flushif,taken,fwda,fwdb}=%b expected %b", name, act, e);
    end
  endtask

  task automatic apply(input string name, input vec_t v);
    ID_Branch = v.ib; ID_Rs = v.rs; ID_Rt = v.rt; Branch = v.br;
    EX_RegWrite = v.exw; EX_MemRead = v.exm; EX_Rd = v.exrd;
    MEM_RegWrite = v.mw; MEM_MemRead = v.mm; MEM_Rd = v.mrd;
    WB_RegWrite = v.ww; WB_Rd = v.wrd; Freeze = v.frz; Flush = v.fl;
    #1;
    check(name, v.exp_out);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[16];
  vec_t nohaz, clr;

  initial begin
    vecs[0]  = mk(1, 3, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0110000);
    vecs[1]  = mk(1, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000);
    vecs[2]  = mk(1, 8, 4, 1, 1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 7'b1000000);
    vecs[3]  = mk(1, 3, 9, 1, 1, 0, 9, 0, 0, 0, 0, 0, 0, 0, 7'b1000000);
    vecs[4]  = mk(1, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0110000);
    vecs[5]  = mk(1, 5, 4, 1, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0, 7'b1000000);
    vecs[6]  = mk(1, 5, 4, 1, 0, 0, 0, 1, 0, 5, 0, 0, 0, 0, 7'b0110100);
    vecs[7]  = mk(1, 3, 6, 1, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 7'b0110010);
    vecs[8]  = mk(1, 7, 7, 0, 0, 0, 0, 1, 0, 7, 1, 7, 0, 0, 7'b0000101);
    vecs[9]  = mk(0, 2, 8, 1, 1, 1, 8, 0, 0, 0, 1, 2, 0, 0, 7'b0001000);
    vecs[10] = mk(1, 3, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0000000);
    vecs[11] = mk(1, 8, 4, 1, 1, 1, 8, 0, 0, 0, 0, 0, 0, 1, 7'b0000000);
    vecs[12] = mk(1, 8, 4, 1, 0, 1, 8, 0, 0, 0, 0, 0, 0, 0, 7'b0110000);
    vecs[13] = mk(1, 6, 4, 1, 0, 0, 0, 0, 0, 0, 0, 6, 0, 0, 7'b0110000);
    vecs[14] = mk(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 7'b0110000);
    vecs[15] = mk(1, 5, 4, 1, 0, 0, 0, 0, 1, 5, 1, 5, 0, 0, 7'b0111000);
    nohaz    = mk(1, 3, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0110000);
    clr      = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000);

    reset = 1'b1;
    apply("reset_state", clr);
`ifdef BR_STAT_EN
    tests++;
    if (StatTaken !== 16'd0 || StatStall !== 16'd0) begin
      fails++;
      $display("FAIL stat_reset: got taken=%0d stall=%0d expected 0/0", StatTaken, StatStall);
    end
`endif
    #11 reset = 1'b0;

    // Single-cycle behaviour from IDLE; each vector starts from a fresh reset.
    for (int unsigned i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      pulse_reset();
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Load-use: two stalls, then resolve with WB forwarding on Rs.
    next_cycle(); pulse_reset();
    apply("ld_stall1", mk(1, 8, 4, 1, 1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 7'b1000000));
    next_cycle();
    apply("ld_stall2", mk(1, 8, 4, 1, 0, 0, 0, 1, 1, 8, 0, 0, 0, 0, 7'b1000000));
    next_cycle();
    apply("ld_resolve", mk(1, 8, 4, 1, 0, 0, 0, 0, 0, 0, 1, 8, 0, 0, 7'b0111000));
    next_cycle();
    apply("ld_after", clr);

    // ALU-use: one stall, resolve not-taken with MEM forwarding on Rt.
    next_cycle(); pulse_reset();
    apply("alu_stall", mk(1, 3, 9, 1, 1, 0, 9, 0, 0, 0, 0, 0, 0, 0, 7'b1000000));
    next_cycle();
    apply("alu_resolve", mk(1, 3, 9, 0, 0, 0, 0, 1, 0, 9, 0, 0, 0, 0, 7'b0000001));
    next_cycle();
    apply("alu_back_idle", nohaz);

    // Freeze for three cycles inside WAIT defers the remaining stall.
    next_cycle(); pulse_reset();
    apply("frz_stall1", mk(1, 8, 4, 1, 1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 7'b1000000));
    for (int unsigned k = 0; k < 3; k++) begin
      next_cycle();
      apply($sformatf("frz_hold%0d", k), mk(1, 3, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0000000));
    end
    next_cycle();
    apply("frz_stall2", mk(1, 3, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1000000));
    next_cycle();
    apply("frz_resolve", nohaz);

    // Flush mid-WAIT returns to IDLE; the next branch resolves immediately.
    next_cycle(); pulse_reset();
`ifdef BR_STAT_EN
    tests++;
    if (StatStall !== 16'd0) begin
      fails++;
      $display("FAIL stat_cleared: got stall=%0d expected 0", StatStall);
    end
`endif
    apply("fl_stall1", mk(1, 8, 4, 1, 1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 7'b1000000));
    next_cycle();
    apply("fl_flush", mk(1, 3, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7'b0000000));
    next_cycle();
    apply("fl_idle", nohaz);
    next_cycle();
`ifdef BR_STAT_EN
    tests++;
    if (StatStall !== 16'd1 || StatTaken !== 16'd1) begin
      fails++;
      $display("FAIL stat_counts: got taken=%0d stall=%0d expected 1/1", StatTaken, StatStall);
    end
`endif

    // Asynchronous reset mid-WAIT clears the stall without a clock edge.
    pulse_reset();
    apply("rst_stall1", mk(1, 8, 4, 1, 1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 7'b1000000));
    next_cycle();
    apply("rst_in_wait", nohaz_stall());
    reset = 1'b1;
    #1;
    check("rst_async", 7'b0000000);
    reset = 1'b0;
    #1;
    check("rst_idle", 7'b0110000);

    next_cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  function automatic vec_t nohaz_stall();
    return mk(1, 3, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1000000);
  endfunction

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
